// File: rtl/axi_rd_arb_pkg.sv
// axi_rd_arb_pkg: shared AR ids, size encodings and the word-match helper
package axi_rd_arb_pkg;

    localparam logic [3:0] ARID_INST = 4'd0;
    localparam logic [3:0] ARID_DATA = 4'd1;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } size_e;

    // Two byte addresses fall in the same 32-bit word (bits [1:0] masked off)
    function automatic logic same_word(input logic [31:0] a, input logic [31:0] b);
        return ((a ^ b) & 32'hffff_fffc) == 32'h0;
    endfunction

endpackage

// File: rtl/axi_outst_cnt.sv
// axi_outst_cnt: per-ID outstanding-read counter, saturating at both ends
module axi_outst_cnt #(
    parameter int MAX = 2,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc_i,
    input  logic         dec_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    // Simultaneous inc and dec cancel; otherwise step within [0, MAX]
    always_comb begin
        cnt_d = (inc_i && !dec_i && cnt_q != W'(MAX)) ? cnt_q + W'(1) :
                (dec_i && !inc_i && cnt_q != '0)      ? cnt_q - W'(1) : cnt_q;
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/axi_rd_arb.sv
// axi_rd_arb: arbitrates IF and EX reads onto one AXI AR channel and routes R back
module axi_rd_arb
    import axi_rd_arb_pkg::*;
#(
    parameter int MAX_OUTST  = 2,
    parameter int STARVE_LIM = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    input  logic [1:0]  inst_size,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic [31:0] data_addr,
    input  logic [1:0]  data_size,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    input  logic        wr_pending,
    input  logic [31:0] wr_pending_addr,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    localparam int CW = $clog2(MAX_OUTST + 1);
    localparam int SW = $clog2(STARVE_LIM + 1);

    logic [CW-1:0] cnt_inst, cnt_data;
    logic [CW:0]   eff_inst, eff_data;
    logic [SW-1:0] starve_q, starve_d;
    logic          arvalid_q, arvalid_d;
    logic [3:0]    arid_q, arid_d;
    logic [31:0]   araddr_q, araddr_d;
    logic [2:0]    arsize_q, arsize_d;
    logic          slot_free, inst_elig, data_elig, inst_win, data_win, ar_hs, r_done;

    // A request sitting in the AR register is already outstanding; count it so a
    // grant issued back-to-back with a handshake cannot overshoot MAX_OUTST
    assign eff_inst  = {1'b0, cnt_inst} + (CW+1)'(arvalid_q && arid_q == ARID_INST);
    assign eff_data  = {1'b0, cnt_data} + (CW+1)'(arvalid_q && arid_q == ARID_DATA);
    assign slot_free = !reset && (!arvalid_q || arready);
    assign inst_elig = inst_req && eff_inst < (CW+1)'(MAX_OUTST);
    assign data_elig = data_req && eff_data < (CW+1)'(MAX_OUTST) &&
                       !(wr_pending && same_word(wr_pending_addr, data_addr));
    assign inst_win  = slot_free && inst_elig && (!data_elig || starve_q == SW'(STARVE_LIM));
    assign data_win  = slot_free && data_elig && !inst_win;
    assign ar_hs     = arvalid_q && arready;
    assign r_done    = rvalid && rlast;

    // Next AR contents: load on a grant, hold while stalled, drop valid after handshake
    always_comb begin
        arvalid_d = inst_win || data_win || (arvalid_q && !arready);
        arid_d    = inst_win ? ARID_INST : data_win ? ARID_DATA : arid_q;
        araddr_d  = inst_win ? inst_addr : data_win ? data_addr : araddr_q;
        arsize_d  = inst_win ? {1'b0, inst_size} : data_win ? {1'b0, data_size} : arsize_q;
        starve_d  = (!inst_req || inst_win) ? '0 :
                    (data_win && starve_q != SW'(STARVE_LIM)) ? starve_q + SW'(1) : starve_q;
    end

    // AR holding register and starvation counter
    always_ff @(posedge clk) begin
        if (reset) begin
            arvalid_q <= 1'b0;
            arid_q    <= '0;
            araddr_q  <= '0;
            arsize_q  <= '0;
            starve_q  <= '0;
        end else begin
            arvalid_q <= arvalid_d;
            arid_q    <= arid_d;
            araddr_q  <= araddr_d;
            arsize_q  <= arsize_d;
            starve_q  <= starve_d;
        end
    end

    axi_outst_cnt #(.MAX(MAX_OUTST), .W(CW)) u_cnt_inst (
        .clk   (clk),
        .reset (reset),
        .inc_i (ar_hs && arid_q == ARID_INST),
        .dec_i (r_done && rid == ARID_INST),
        .cnt_o (cnt_inst)
    );

    axi_outst_cnt #(.MAX(MAX_OUTST), .W(CW)) u_cnt_data (
        .clk   (clk),
        .reset (reset),
        .inc_i (ar_hs && arid_q == ARID_DATA),
        .dec_i (r_done && rid == ARID_DATA),
        .cnt_o (cnt_data)
    );

    assign inst_addr_ok = inst_win;
    assign data_addr_ok = data_win;
    assign arvalid      = arvalid_q;
    assign arid         = arid_q;
    assign araddr       = araddr_q;
    assign arsize       = arsize_q;
    assign rready       = 1'b1;
    assign inst_data_ok = !reset && rvalid && rid == ARID_INST;
    assign data_data_ok = !reset && rvalid && rid == ARID_DATA;
    assign inst_rdata   = rdata;
    assign data_rdata   = rdata;

endmodule

// File: tb/tb_axi_rd_arb.sv
// tb_axi_rd_arb: scoreboard bench for the AR arbiter with a simple R responder
module tb_axi_rd_arb;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [2:0]  size;
    } ar_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, data_req, wr_pending, arready, rlast, rvalid;
    logic [31:0] inst_addr, data_addr, wr_pending_addr, rdata;
    logic [1:0]  inst_size, data_size;
    logic [3:0]  rid;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, arvalid, rready;
    logic [31:0] inst_rdata, data_rdata, araddr;
    logic [3:0]  arid;
    logic [2:0]  arsize;

    int    n_cmp = 0;
    int    n_err = 0;
    int    hs_cnt = 0;
    int    resp_budget = 0;
    logic  g_i, g_d;
    ar_t   exp_ar[$];
    beat_t resp_q[$];
    beat_t exp_r[$];

    axi_rd_arb #(.MAX_OUTST(2), .STARVE_LIM(4)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_size(inst_size),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_addr(data_addr), .data_size(data_size),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .wr_pending(wr_pending), .wr_pending_addr(wr_pending_addr),
        .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] resp_data(input logic [31:0] a);
        return a ^ 32'h0e34_5678;
    endfunction

    // One clock: sample/check mid-cycle, then drive the responder after the edge
    task automatic step();
        ar_t   e;
        beat_t b;
        @(negedge clk);
        g_i = inst_addr_ok;
        g_d = data_addr_ok;
        if (g_i || g_d) chk("one_grant", 32'(g_i & g_d), 32'd0);
        if (arvalid && arready) begin
            if (exp_ar.size() == 0) chk("ar_unexpected", 32'(arvalid), 32'd0);
            else begin
                e = exp_ar.pop_front();
                chk("ar_id", 32'(arid), 32'(e.id));
                chk("ar_addr", araddr, e.addr);
                chk("ar_size", 32'(arsize), 32'(e.size));
            end
            b.id = arid;
            b.data = resp_data(araddr);
            resp_q.push_back(b);
            hs_cnt++;
        end
        if (rvalid) begin
            if (exp_r.size() == 0) chk("r_unexpected", 32'(rvalid), 32'd0);
            else begin
                b = exp_r.pop_front();
                chk("r_inst_ok", 32'(inst_data_ok), 32'(b.id == 4'd0));
                chk("r_data_ok", 32'(data_data_ok), 32'(b.id == 4'd1));
                chk("r_rdata", (b.id == 4'd0) ? inst_rdata : data_rdata, b.data);
            end
        end
        if (g_i) begin e.id = 4'd0; e.addr = inst_addr; e.size = {1'b0, inst_size}; exp_ar.push_back(e); end
        if (g_d) begin e.id = 4'd1; e.addr = data_addr; e.size = {1'b0, data_size}; exp_ar.push_back(e); end
        @(posedge clk);
        #1;
        if (resp_budget > 0 && resp_q.size() > 0) begin
            b = resp_q.pop_front();
            rvalid = 1'b1; rid = b.id; rdata = b.data; rlast = 1'b1;
            exp_r.push_back(b);
            resp_budget--;
        end else begin
            rvalid = 1'b0; rid = 4'd0; rdata = 32'd0; rlast = 1'b0;
        end
    endtask

    task automatic drain();
        for (int c = 0; c < 40; c++) begin
            if (!arvalid && !rvalid && resp_q.size() == 0 && exp_r.size() == 0) break;
            step();
        end
        chk("drain_idle", 32'(arvalid || rvalid || resp_q.size() != 0), 32'd0);
    endtask

    initial begin
        int ng, nd, got, hs0;
        int order[8];
        int exp_order[7] = '{1, 1, 1, 1, 0, 1, 1};
        logic inst_done;
        reset = 1'b1; inst_req = 1'b1; data_req = 1'b1; wr_pending = 1'b0; arready = 1'b1;
        inst_addr = 32'h1c00_0000; data_addr = 32'h0000_1000; wr_pending_addr = 32'd0;
        inst_size = 2'd2; data_size = 2'd2; rvalid = 1'b0; rid = 4'd0; rdata = 32'd0; rlast = 1'b0;
        repeat (2) step();
        chk("rst_inst_addr_ok", 32'(g_i), 32'd0);
        chk("rst_data_addr_ok", 32'(g_d), 32'd0);
        chk("rst_arvalid", 32'(arvalid), 32'd0);
        chk("rst_arid", 32'(arid), 32'd0);
        chk("rst_araddr", araddr, 32'd0);
        chk("rst_arsize", 32'(arsize), 32'd0);
        chk("rst_rready", 32'(rready), 32'd1);
        chk("rst_starve", 32'(dut.starve_q), 32'd0);
        reset = 1'b0; inst_req = 1'b0; data_req = 1'b0; resp_budget = 1 << 20;
        step();

        // inst only
        inst_req = 1'b1; inst_addr = 32'h1c00_0000;
        step();
        chk("if_addr_ok", 32'(g_i), 32'd1);
        inst_req = 1'b0;
        chk("if_arvalid", 32'(arvalid), 32'd1);
        chk("if_arid", 32'(arid), 32'd0);
        chk("if_araddr", araddr, 32'h1c00_0000);
        chk("if_arsize", 32'(arsize), 32'd2);
        drain();

        // simultaneous: data wins first
        inst_req = 1'b1; data_req = 1'b1; inst_addr = 32'h1c00_0010; data_addr = 32'h0000_2000;
        step();
        chk("sim_data_ok", 32'(g_d), 32'd1);
        chk("sim_inst_ok", 32'(g_i), 32'd0);
        chk("sim_arid", 32'(arid), 32'd1);
        data_req = 1'b0;
        step();
        chk("sim_inst_next", 32'(g_i), 32'd1);
        inst_req = 1'b0;
        drain();

        // starvation with AR handshakes every other cycle
        ng = 0; nd = 0; inst_done = 1'b0; inst_addr = 32'h1c00_0100;
        for (int c = 0; c < 80 && nd < 6; c++) begin
            arready = (c % 2) == 1;
            inst_req = !inst_done;
            data_req = 1'b1;
            data_addr = 32'h0000_3000 + 32'(4 * nd);
            step();
            if (g_d && ng < 8) begin order[ng] = 1; ng++; nd++; end
            if (g_i && ng < 8) begin
                order[ng] = 0; ng++; inst_done = 1'b1;
                chk("starve_clear", 32'(dut.starve_q), 32'd0);
            end
        end
        inst_req = 1'b0; data_req = 1'b0; arready = 1'b1;
        chk("starve_ngrants", 32'(ng), 32'd7);
        for (int k = 0; k < 7; k++) chk($sformatf("starve_order%0d", k), 32'(order[k]), 32'(exp_order[k]));
        drain();

        // outstanding limit
        resp_budget = 0; ng = 0; hs0 = hs_cnt; inst_req = 1'b1; inst_addr = 32'h1c00_0200;
        repeat (5) begin
            step();
            if (g_i) ng++;
        end
        chk("outst_grants", 32'(ng), 32'd2);
        chk("outst_handshakes", 32'(hs_cnt - hs0), 32'd2);
        chk("outst_blocked", 32'(g_i), 32'd0);
        resp_budget = 1; got = 0;
        for (int c = 0; c < 6 && got == 0; c++) begin
            step();
            if (g_i) got = 1;
        end
        chk("outst_third", 32'(got), 32'd1);
        inst_req = 1'b0; resp_budget = 1 << 20;
        drain();

        // read-after-write block
        wr_pending = 1'b1; wr_pending_addr = 32'h0000_0800; data_req = 1'b1;
        data_addr = 32'h0000_0802; data_size = 2'd1;
        step();
        chk("raw_block0", 32'(g_d), 32'd0);
        step();
        chk("raw_block1", 32'(g_d), 32'd0);
        wr_pending = 1'b0;
        step();
        chk("raw_release", 32'(g_d), 32'd1);
        wr_pending = 1'b1; data_addr = 32'h0000_0804; data_size = 2'd2;
        step();
        chk("raw_other_word", 32'(g_d), 32'd1);
        data_req = 1'b0; wr_pending = 1'b0;
        drain();

        // backpressure then reset mid-stall
        resp_budget = 0; data_req = 1'b1; data_addr = 32'h0000_0040;
        step();
        chk("bp_grant0", 32'(g_d), 32'd1);
        data_addr = 32'h0000_0044;
        step();
        chk("bp_grant1", 32'(g_d), 32'd1);
        arready = 1'b0; data_addr = 32'h0000_0048; inst_req = 1'b1;
        repeat (3) begin
            step();
            chk("bp_data_ok", 32'(g_d), 32'd0);
            chk("bp_inst_ok", 32'(g_i), 32'd0);
            chk("bp_arvalid", 32'(arvalid), 32'd1);
            chk("bp_araddr", araddr, 32'h0000_0044);
            chk("bp_arid", 32'(arid), 32'd1);
        end
        chk("bp_cnt_data_pre", 32'(dut.cnt_data), 32'd1);
        reset = 1'b1;
        step();
        chk("mrst_inst_ok", 32'(g_i), 32'd0);
        chk("mrst_data_ok", 32'(g_d), 32'd0);
        chk("mrst_arvalid", 32'(arvalid), 32'd0);
        chk("mrst_cnt_data", 32'(dut.cnt_data), 32'd0);
        chk("mrst_cnt_inst", 32'(dut.cnt_inst), 32'd0);
        exp_ar.delete(); resp_q.delete(); exp_r.delete();
        reset = 1'b0; inst_req = 1'b0; data_req = 1'b0; arready = 1'b1;
        step();
        chk("end_arvalid", 32'(arvalid), 32'd0);
        chk("end_exp_ar_empty", 32'(exp_ar.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/axi_rd_arb.md
Name: axi_rd_arb

Overview:
- Sequencer for the shared AXI read-address channel of the core.
- Arbitrates read requests from instruction fetch (IF) and data load (EX) onto a single AR channel.
- Tracks outstanding reads per ID and blocks data reads that hit a pending store (read-after-write hazard).
- Routes R-channel responses back to the owning requester.
- Sits between the IF/EX SRAM-like interfaces and the AXI master port in the core top; the write path is a separate block that supplies the pending-store signals.

Parameters:
- MAX_OUTST, 2, maximum outstanding reads per requester ID (1..3)
- STARVE_LIM, 4, consecutive data grants while IF waits before IF is forced to win

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- inst_req  in  1  IF read request
- inst_addr  in  32  IF byte address
- inst_size  in  2  IF size (0=byte, 1=half, 2=word)
- inst_addr_ok  out  1  IF request accepted this cycle
- inst_data_ok  out  1  IF read data valid
- inst_rdata  out  32  IF read data
- data_req  in  1  EX load request
- data_addr  in  32  EX byte address
- data_size  in  2  EX size
- data_addr_ok  out  1  EX request accepted this cycle
- data_data_ok  out  1  EX read data valid
- data_rdata  out  32  EX read data
- wr_pending  in  1  write path holds an uncompleted store
- wr_pending_addr  in  32  address of that store
- arid  out  4  0 = inst, 1 = data
- araddr  out  32  read address
- arsize  out  3  {1'b0, size}
- arvalid  out  1  AR valid
- arready  in  1  AR ready
- rid  in  4  response ID
- rdata  in  32  response data
- rlast  in  1  last beat
- rvalid  in  1  R valid
- rready  out  1  R ready

Behaviour:
- Clock/reset (already decided): one clock `clk`; `reset` is synchronous and active-high.
- Reset values: arvalid=0, arid/araddr/arsize=0, both outstanding counters=0, starve counter=0, rready=1. The addr_ok/data_ok outputs are combinational and read 0 while reset is held.
- AR holding register: arid/araddr/arsize/arvalid are registered.
  - Slot free when !arvalid || arready.
  - While arvalid && !arready, the AR fields are held stable (AXI rule).
- Grant, combinational, in a cycle where the slot is free:
  - data eligible = data_req && cnt_d<MAX_OUTST && !(wr_pending && wr_pending_addr[31:2]==data_addr[31:2])
  - inst eligible = inst_req && cnt_i<MAX_OUTST
  - Default priority: data first. Inst wins instead when starve==STARVE_LIM and inst is eligible.
  - The winner's *_addr_ok=1; that request loads the AR register next edge with arvalid=1. The loser's addr_ok=0.
- Back-to-back issue: a new grant is allowed in the same cycle as an AR handshake. Maximum throughput is one AR per cycle.
- Starve counter:
  - increments (saturating at STARVE_LIM) on a data grant while inst_req=1;
  - clears on an inst grant or when inst_req=0.
- Outstanding counters:
  - +1 on AR handshake (arvalid && arready) for arid;
  - -1 on rvalid && rready && rlast for rid;
  - simultaneous +1 and -1 on the same ID leaves the count unchanged.
  - The count is checked at grant time, so it never exceeds MAX_OUTST.
- R routing: rready is tied to 1.
  - inst_data_ok = rvalid && rid==0; data_data_ok = rvalid && rid==1.
  - Both *_rdata = rdata.
  - rresp is ignored; rid values other than 0/1 are not generated.
- Ordering: responses within one ID return in order (AXI same-ID rule); no reordering buffer.
- Reset mid-operation: counters and the AR register are cleared. In-flight responses are the interconnect's responsibility, since it is reset by the same signal.
- Width rules: address compare uses bits [31:2] only; counters are $clog2(MAX_OUTST+1) bits.

Decomposition:
- Shared constants file: ARID_INST=4'd0, ARID_DATA=4'd1, size encodings.
- One natural sub-module: axi_outst_cnt, a per-ID up/down saturating counter, instantiated twice.

Test Plan:
- Inst only: inst_req=1 at 0x1c000000, arready=1 -> inst_addr_ok same cycle; next cycle arvalid=1, arid=0, araddr=0x1c000000, arsize=3'b010. With rvalid, rid=0, rdata=0x12345678, rlast=1 -> inst_data_ok=1, inst_rdata=0x12345678.
- Simultaneous requests: inst_req and data_req both high at the same time -> data_addr_ok=1, inst_addr_ok=0; AR carries arid=1 first.
- Starvation: data_req held high for 6 requests with inst_req high -> inst granted on the 5th grant slot (after 4 data grants); starve counter clears.
- Outstanding limit: arready=1, rvalid=0; issue 3 inst reads -> 2 handshakes, 3rd inst_addr_ok=0. One R last with rid=0 -> 3rd granted.
- RAW block: wr_pending=1, wr_pending_addr=0x800; data_req at 0x802 -> data_addr_ok=0. Drop wr_pending -> granted. A data read at 0x804 is granted even while wr_pending=1.
- AR backpressure and reset: arready=0 for 3 cycles -> araddr/arid stable, no further grants. Assert reset mid-stall -> arvalid=0 and counters=0 next edge.
